pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS datapath. It generates the write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions:
- load-use hazards, by stalling and injecting a bubble into ID/EX;
- taken branches and jumps resolved in ID, by flushing IF/ID;
- multi-cycle data-memory accesses, by freezing the pipeline until memory acknowledges.

It sits beside the pipeline registers in the CPU top level and is their only source of hold/flush control.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_perf_cnt.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Control bundle layout is shared by the top and the perf counters.
package hazard_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int MEM_TIMEOUT_DEF = 255;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic memwb_bubble;
        logic stall;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and hold/flush controls between datapath and controller.
// master = datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
);

    logic                  IDEX_MemRead_i;
    logic [REG_ADDR_W-1:0] IDEX_rt_i;
    logic [REG_ADDR_W-1:0] IFID_rs_i;
    logic [REG_ADDR_W-1:0] IFID_rt_i;
    logic                  IFID_rtUsed_i;
    logic                  branch_taken_i;
    logic                  jump_i;
    logic                  dmem_req_i;
    logic                  dmem_ack_i;
    logic                  PC_write_o;
    logic                  IFID_write_o;
    logic                  IFID_flush_o;
    logic                  IDEX_write_o;
    logic                  IDEX_flush_o;
    logic                  EXMEM_write_o;
    logic                  MEMWB_bubble_o;
    logic                  stall_o;
    logic                  mem_timeout_o;
    logic [31:0]           stall_cnt_o;
    logic [31:0]           flush_cnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_rt_i, IFID_rs_i, IFID_rt_i,
        output IFID_rtUsed_i, branch_taken_i, jump_i,
        output dmem_req_i, dmem_ack_i,
        input  PC_write_o, IFID_write_o, IFID_flush_o,
        input  IDEX_write_o, IDEX_flush_o, EXMEM_write_o,
        input  MEMWB_bubble_o, stall_o, mem_timeout_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_rt_i, IFID_rs_i, IFID_rt_i,
        input  IFID_rtUsed_i, branch_taken_i, jump_i,
        input  dmem_req_i, dmem_ack_i,
        output PC_write_o, IFID_write_o, IFID_flush_o,
        output IDEX_write_o, IDEX_flush_o, EXMEM_write_o,
        output MEMWB_bubble_o, stall_o, mem_timeout_o,
        output stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Wrapping 32-bit stall and flush cycle counters.
module hazard_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall_i);
        flush_cnt_d = flush_cnt_q + 32'(flush_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/flush sequencing for the 5-stage pipeline registers.
// Optional perf counters under `HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = hazard_pkg::MEM_TIMEOUT_DEF,
    parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_hazard_ctrl_if.slave bus
);

    import hazard_pkg::*;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] wait_cnt_d, wait_cnt_q;
    logic             timeout_d, timeout_q;
    ctrl_t            ctrl;
    logic             freeze;
    logic             load_use;
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;

    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;

    assign ex_rt = bus.IDEX_rt_i;
    assign id_rs = bus.IFID_rs_i;
    assign id_rt = bus.IFID_rt_i;

    assign load_use = bus.IDEX_MemRead_i && (ex_rt != '0) &&
                      ((ex_rt == id_rs) ||
                       (bus.IFID_rtUsed_i && (ex_rt == id_rt)));

    // In MEM_WAIT the request is already accepted; only ack matters.
    assign freeze = (state_q == MEM_WAIT) ? !bus.dmem_ack_i
                  : (bus.dmem_req_i && !bus.dmem_ack_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            RUN: begin
                if (bus.dmem_req_i && !bus.dmem_ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q == CNT_MAX) timeout_d = 1'b1;
                if (bus.dmem_ack_i) begin
                    state_d = RUN;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (!rst_i) begin
            ctrl.pc_write    = 1'b1;
            ctrl.ifid_write  = 1'b1;
            ctrl.idex_write  = 1'b1;
            ctrl.exmem_write = 1'b1;
            if (freeze) begin
                ctrl.pc_write     = 1'b0;
                ctrl.ifid_write   = 1'b0;
                ctrl.idex_write   = 1'b0;
                ctrl.exmem_write  = 1'b0;
                ctrl.memwb_bubble = 1'b1;
                ctrl.stall        = 1'b1;
            end else if (load_use) begin
                // Branch in ID is held and re-resolves next cycle.
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_write = 1'b0;
                ctrl.idex_flush = 1'b1;
                ctrl.stall      = 1'b1;
            end else if (bus.branch_taken_i || bus.jump_i) begin
                ctrl.ifid_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (ctrl.stall),
        .flush_i     (ctrl.ifid_flush),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign bus.PC_write_o     = ctrl.pc_write;
    assign bus.IFID_write_o   = ctrl.ifid_write;
    assign bus.IFID_flush_o   = ctrl.ifid_flush;
    assign bus.IDEX_write_o   = ctrl.idex_write;
    assign bus.IDEX_flush_o   = ctrl.idex_flush;
    assign bus.EXMEM_write_o  = ctrl.exmem_write;
    assign bus.MEMWB_bubble_o = ctrl.memwb_bubble;
    assign bus.stall_o        = ctrl.stall;
    assign bus.mem_timeout_o  = timeout_q;
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // {PC_w, IFID_w, IFID_fl, IDEX_w, IDEX_fl, EXMEM_w, MEMWB_bub, stall}
    localparam logic [7:0] C_NORM = 8'b1101_0100;
    localparam logic [7:0] C_LU   = 8'b0001_1101;
    localparam logic [7:0] C_FL   = 8'b1111_0100;
    localparam logic [7:0] C_FRZ  = 8'b0000_0011;
    localparam logic [7:0] C_OFF  = 8'b0000_0000;

    function automatic logic [7:0] obs();
        return {bus.PC_write_o, bus.IFID_write_o, bus.IFID_flush_o,
                bus.IDEX_write_o, bus.IDEX_flush_o, bus.EXMEM_write_o,
                bus.MEMWB_bubble_o, bus.stall_o};
    endfunction

    task automatic drv(input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rtu, input logic br, input logic j,
                       input logic req, input logic ack);
        bus.IDEX_MemRead_i = mr;
        bus.IDEX_rt_i      = ert;
        bus.IFID_rs_i      = rs;
        bus.IFID_rt_i      = rt;
        bus.IFID_rtUsed_i  = rtu;
        bus.branch_taken_i = br;
        bus.jump_i         = j;
        bus.dmem_req_i     = req;
        bus.dmem_ack_i     = ack;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1, 8, 8, 0, 0, 1, 0, 1, 0);
        tests++;
        if (obs() !== C_OFF) begin
            failed++; $display("FAIL rst_ctrl: got %b want %b", obs(), C_OFF);
        end
        tests++;
        if (bus.mem_timeout_o !== 1'b0) begin
            failed++; $display("FAIL rst_tmo: got %b want 0", bus.mem_timeout_o);
        end
        tests++;
        if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
            failed++;
            $display("FAIL rst_cnt: got %0d/%0d want 0/0",
                     bus.stall_cnt_o, bus.flush_cnt_o);
        end
        adv();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL post_rst: got %b want %b", obs(), C_NORM);
        end
    endtask

    task automatic test_load_use();
        drv(1, 8, 8, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_LU) begin
            failed++; $display("FAIL lu_rs: got %b want %b", obs(), C_LU);
        end
        adv();
        drv(0, 0, 8, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL lu_bubble: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL lu_r0: got %b want %b", obs(), C_NORM);
        end
        drv(1, 8, 3, 8, 1, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_LU) begin
            failed++; $display("FAIL lu_rt: got %b want %b", obs(), C_LU);
        end
        drv(1, 8, 3, 8, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL lu_rt_unused: got %b want %b", obs(), C_NORM);
        end
        adv();
    endtask

    task automatic test_branch();
        drv(1, 8, 8, 0, 0, 1, 0, 0, 0);
        tests++;
        if (obs() !== C_LU) begin
            failed++; $display("FAIL lu_br: got %b want %b", obs(), C_LU);
        end
        adv();
        drv(0, 0, 8, 0, 0, 1, 0, 0, 0);
        tests++;
        if (obs() !== C_FL) begin
            failed++; $display("FAIL br_flush: got %b want %b", obs(), C_FL);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tests++;
        if (obs() !== C_FL) begin
            failed++; $display("FAIL jump_flush: got %b want %b", obs(), C_FL);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL br_after: got %b want %b", obs(), C_NORM);
        end
        adv();
    endtask

    task automatic test_mem();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (obs() !== C_FRZ) begin
                failed++;
                $display("FAIL mem_frz%0d: got %b want %b", i, obs(), C_FRZ);
            end
            adv();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL mem_ack: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL mem_run: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL mem_hit: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL hit_after: got %b want %b", obs(), C_NORM);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL stray_ack: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL stray_after: got %b want %b", obs(), C_NORM);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        adv();
        drv(1, 8, 8, 0, 0, 0, 0, 1, 1);
        tests++;
        if (obs() !== C_LU) begin
            failed++; $display("FAIL ack_lu: got %b want %b", obs(), C_LU);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
    endtask

    task automatic test_timeout();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        adv();
        repeat (4) adv();
        tests++;
        if (bus.mem_timeout_o !== 1'b0 || obs() !== C_FRZ) begin
            failed++;
            $display("FAIL tmo_early: got tmo=%b ctrl=%b want 0 %b",
                     bus.mem_timeout_o, obs(), C_FRZ);
        end
        adv();
        tests++;
        if (bus.mem_timeout_o !== 1'b1) begin
            failed++; $display("FAIL tmo_set: got %b want 1", bus.mem_timeout_o);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL tmo_ack: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        tests++;
        if (bus.mem_timeout_o !== 1'b1 || obs() !== C_NORM) begin
            failed++;
            $display("FAIL tmo_sticky: got tmo=%b ctrl=%b want 1 %b",
                     bus.mem_timeout_o, obs(), C_NORM);
        end
    endtask

    task automatic test_reset_mid_wait();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        adv();
        adv();
        rst = 1'b1;
        #1;
        tests++;
        if (obs() !== C_OFF || bus.mem_timeout_o !== 1'b0) begin
            failed++;
            $display("FAIL rst_wait: got ctrl=%b tmo=%b want %b 0",
                     obs(), bus.mem_timeout_o, C_OFF);
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL late_ack: got %b want %b", obs(), C_NORM);
        end
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== C_NORM) begin
            failed++; $display("FAIL rst_run: got %b want %b", obs(), C_NORM);
        end
        adv();
    endtask

    task automatic test_perf();
        logic [31:0] exp_s;
        logic [31:0] exp_f;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drv(1, 8, 8, 0, 0, 1, 0, 0, 0);
        adv();
        drv(0, 0, 8, 0, 0, 1, 0, 0, 0);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) adv();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
`ifdef HAZARD_PERF_CNT_EN
        exp_s = 32'd4;
        exp_f = 32'd1;
`else
        exp_s = 32'd0;
        exp_f = 32'd0;
`endif
        tests++;
        if (bus.stall_cnt_o !== exp_s) begin
            failed++;
            $display("FAIL stall_cnt: got %0d want %0d", bus.stall_cnt_o, exp_s);
        end
        tests++;
        if (bus.flush_cnt_o !== exp_f) begin
            failed++;
            $display("FAIL flush_cnt: got %0d want %0d", bus.flush_cnt_o, exp_f);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem();
        test_timeout();
        test_reset_mid_wait();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
